// File: rtl/sram_sp_init_ext_if.sv
// Request/response bundle for sram_sp_init_ext: the client drives the master side and the array drives the slave side.
// The array sees no backpressure: a request is only taken while RW0_ready is high.
interface sram_sp_init_ext_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 320,
  parameter int MASK_WIDTH = 10
);
  logic [ADDR_WIDTH-1:0] RW0_addr;
  logic                  RW0_en;
  logic                  RW0_wmode;
  logic [MASK_WIDTH-1:0] RW0_wmask;
  logic [DATA_WIDTH-1:0] RW0_wdata;
  logic                  init_req;
  logic                  RW0_ready;
  logic                  RW0_rvalid;
  logic [DATA_WIDTH-1:0] RW0_rdata;

  modport master (
    output RW0_addr, RW0_en, RW0_wmode, RW0_wmask, RW0_wdata, init_req,
    input  RW0_ready, RW0_rvalid, RW0_rdata
  );

  modport slave (
    input  RW0_addr, RW0_en, RW0_wmode, RW0_wmask, RW0_wdata, init_req,
    output RW0_ready, RW0_rvalid, RW0_rdata
  );
endinterface

// File: rtl/sram_sp_init_ext.sv
// Single-port masked-write SRAM with a self-init engine; if SRAM_GARBAGE_RDATA_EN is defined, rdata is randomised whenever rvalid is low (simulation only).
// Read latency is RD_LATENCY (1 or 2) cycles. There is no backpressure: requests are taken only while RW0_ready is high and are dropped otherwise.
module sram_sp_init_ext #(
  parameter int DATA_WIDTH = 320,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = 10,
  parameter int MASK_GRAN  = 32,
  parameter int RD_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input logic            RW0_clk,
  input logic            reset,
  sram_sp_init_ext_if.slave rw
);
  localparam int MASK_WIDTH = DATA_WIDTH / MASK_GRAN;
  localparam int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] LAST_W  = (ADDR_WIDTH+1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
    $error("sram_sp_init_ext: RD_LATENCY must be 1 or 2");
  end
  if (DATA_WIDTH % MASK_GRAN != 0) begin : g_bad_gran
    $error("sram_sp_init_ext: DATA_WIDTH must be a multiple of MASK_GRAN");
  end

  typedef enum logic {INIT, READY} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] ram [DEPTH];

  logic                  take_init, acc, in_rng, wr_acc, rd_acc;
  logic [IDX_W-1:0]      req_idx, init_idx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  dlv_vld;
  logic [DATA_WIDTH-1:0] dlv_dat;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  // A reinit request on the same edge as an access wins; the access is dropped.
  assign take_init = (state_q == READY) && rw.init_req;
  assign acc       = (state_q == READY) && !rw.init_req && rw.RW0_en;
  assign in_rng    = {1'b0, rw.RW0_addr} < DEPTH_W;
  assign wr_acc    = acc && rw.RW0_wmode && in_rng;
  assign rd_acc    = acc && !rw.RW0_wmode;
  assign req_idx   = rw.RW0_addr[IDX_W-1:0];
  assign init_idx  = cnt_q[IDX_W-1:0];
  assign rd_word   = in_rng ? ram[req_idx] : '0;

  always_ff @(posedge RW0_clk or posedge reset) begin
    if (reset) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_W) state_d = READY;
      end
      READY: begin
        if (rw.init_req) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge RW0_clk) begin
    if (state_q == INIT) begin
      ram[init_idx] <= INIT_VALUE;
    end else if (wr_acc) begin
      for (int i = 0; i < MASK_WIDTH; i++) begin
        if (rw.RW0_wmask[i])
          ram[req_idx][i*MASK_GRAN +: MASK_GRAN] <= rw.RW0_wdata[i*MASK_GRAN +: MASK_GRAN];
      end
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic                  p1_vld_q;
    logic [DATA_WIDTH-1:0] p1_dat_q;

    always_ff @(posedge RW0_clk or posedge reset) begin
      if (reset) begin
        p1_vld_q <= 1'b0;
        p1_dat_q <= '0;
      end else begin
        p1_vld_q <= rd_acc;
        if (rd_acc) p1_dat_q <= rd_word;
      end
    end

    // A read still in the first stage when reinit is taken is discarded.
    assign dlv_vld = p1_vld_q && !take_init;
    assign dlv_dat = p1_dat_q;
  end else begin : g_lat1
    assign dlv_vld = rd_acc;
    assign dlv_dat = rd_word;
  end

  always_ff @(posedge RW0_clk or posedge reset) begin
    if (reset) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= dlv_vld;
      if (dlv_vld) rdata_q <= dlv_dat;
    end
  end

  assign rw.RW0_ready  = (state_q == READY);
  assign rw.RW0_rvalid = rvalid_q;

`ifdef SRAM_GARBAGE_RDATA_EN
  localparam int NWORDS = (DATA_WIDTH + 31) / 32;
  logic [NWORDS*32-1:0] garb_q;

  always_ff @(posedge RW0_clk or posedge reset) begin
    if (reset) begin
      garb_q <= '0;
    end else begin
      for (int i = 0; i < NWORDS; i++) garb_q[i*32 +: 32] <= $random;
    end
  end

  assign rw.RW0_rdata = rvalid_q ? rdata_q : garb_q[DATA_WIDTH-1:0];
`else
  assign rw.RW0_rdata = rdata_q;
`endif
endmodule

// File: tb/tb_sram_sp_init_ext.sv
// Directed bench: u1 is DEPTH 1024 / latency 1 / zero init, and u2 is DEPTH 1000 / latency 2 / patterned init.
// Both instances receive the same stimulus.
module tb_sram_sp_init_ext;
  localparam logic [1:0] OP_IDLE = 2'd0;
  localparam logic [1:0] OP_RD   = 2'd1;
  localparam logic [1:0] OP_WR   = 2'd2;
  localparam logic [319:0] INIT2 = {10{32'hDEAD_BEEF}};
  localparam int NV = 20;

  typedef struct packed {
    logic [1:0]   op;
    logic [9:0]   addr;
    logic [9:0]   wmask;
    logic [319:0] wdata;
    logic [319:0] exp1;
    logic [319:0] exp2;
  } vec_t;

  logic         RW0_clk;
  logic         rst;
  logic [9:0]   addr;
  logic         en;
  logic         wmode;
  logic [9:0]   wmask;
  logic [319:0] wdata;
  logic         init_req;

  int checks = 0;
  int failures = 0;
  logic [319:0] hold1, hold2;
  vec_t vecs [NV];

  sram_sp_init_ext_if #(.ADDR_WIDTH(10), .DATA_WIDTH(320), .MASK_WIDTH(10)) if1 ();
  sram_sp_init_ext_if #(.ADDR_WIDTH(10), .DATA_WIDTH(320), .MASK_WIDTH(10)) if2 ();

  assign if1.RW0_addr  = addr;
  assign if1.RW0_en    = en;
  assign if1.RW0_wmode = wmode;
  assign if1.RW0_wmask = wmask;
  assign if1.RW0_wdata = wdata;
  assign if1.init_req  = init_req;
  assign if2.RW0_addr  = addr;
  assign if2.RW0_en    = en;
  assign if2.RW0_wmode = wmode;
  assign if2.RW0_wmask = wmask;
  assign if2.RW0_wdata = wdata;
  assign if2.init_req  = init_req;

  sram_sp_init_ext #(
    .DATA_WIDTH(320), .DEPTH(1024), .ADDR_WIDTH(10), .MASK_GRAN(32),
    .RD_LATENCY(1), .INIT_VALUE('0)
  ) u1 (.RW0_clk(RW0_clk), .reset(rst), .rw(if1.slave));

  sram_sp_init_ext #(
    .DATA_WIDTH(320), .DEPTH(1000), .ADDR_WIDTH(10), .MASK_GRAN(32),
    .RD_LATENCY(2), .INIT_VALUE(INIT2)
  ) u2 (.RW0_clk(RW0_clk), .reset(rst), .rw(if2.slave));

  initial RW0_clk = 1'b0;
  always #5 RW0_clk = ~RW0_clk;

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [9:0] a, input logic [9:0] m, input logic [319:0] d);
    en    = (op != OP_IDLE);
    wmode = (op == OP_WR);
    addr  = a;
    wmask = m;
    wdata = d;
  endtask

  function automatic vec_t mk(input logic [1:0] op, input logic [9:0] a, input logic [9:0] m,
                              input logic [319:0] d, input logic [319:0] e1, input logic [319:0] e2);
    vec_t v;
    v.op = op; v.addr = a; v.wmask = m; v.wdata = d; v.exp1 = e1; v.exp2 = e2;
    return v;
  endfunction

  // Counts edges until each instance raises ready. When poke is set, a write and a read are issued mid-init.
  task automatic wait_ready(input int exp1, input int exp2, input bit poke);
    int c1 = 0;
    int c2 = 0;
    bit seen = 1'b0;
    for (int c = 1; c <= 1200 && (c1 == 0 || c2 == 0); c++) begin
      @(negedge RW0_clk);
      if (if1.RW0_rvalid || if2.RW0_rvalid) seen = 1'b1;
      if (if1.RW0_ready && c1 == 0) c1 = c;
      if (if2.RW0_ready && c2 == 0) c2 = c;
      if (poke && c == 10)      drive(OP_WR, 10'd9, 10'h3FF, {10{32'h7777_7777}});
      else if (poke && c == 11) drive(OP_RD, 10'd9, 10'h000, '0);
      else                      drive(OP_IDLE, '0, '0, '0);
    end
    chk("init_len_u1", 320'(c1), 320'(exp1));
    chk("init_len_u2", 320'(c2), 320'(exp2));
    chk("init_no_rvalid", 320'(seen), 320'(0));
  endtask

  initial begin
    logic [319:0] lidx, w5a, w5b, da, db, dc, dd, de, df;
    for (int i = 0; i < 10; i++) lidx[i*32 +: 32] = 32'(i);
    w5a = '0;    w5a[95:64] = 32'd2;
    w5b = INIT2; w5b[31:0] = 32'd0; w5b[95:64] = 32'd2;
    da = {10{32'h1111_1111}}; db = {10{32'h2222_2222}}; dc = {10{32'h3333_3333}};
    dd = {10{32'h4444_4444}}; de = {10{32'h5555_5555}}; df = {10{32'h6666_6666}};

    vecs[0]  = mk(OP_WR,   10'd5,    10'h005, lidx, '0, '0);
    vecs[1]  = mk(OP_RD,   10'd5,    10'h000, '0, w5a, w5b);
    vecs[2]  = mk(OP_WR,   10'd1,    10'h3FF, da, '0, '0);
    vecs[3]  = mk(OP_WR,   10'd2,    10'h3FF, db, '0, '0);
    vecs[4]  = mk(OP_WR,   10'd3,    10'h3FF, dc, '0, '0);
    vecs[5]  = mk(OP_RD,   10'd1,    10'h000, '0, da, da);
    vecs[6]  = mk(OP_RD,   10'd2,    10'h000, '0, db, db);
    vecs[7]  = mk(OP_RD,   10'd3,    10'h000, '0, dc, dc);
    vecs[8]  = mk(OP_WR,   10'd2,    10'h3FF, dd, '0, '0);
    vecs[9]  = mk(OP_IDLE, 10'd0,    10'h000, '0, '0, '0);
    vecs[10] = mk(OP_RD,   10'd1000, 10'h000, '0, '0, '0);
    vecs[11] = mk(OP_WR,   10'd1000, 10'h3FF, de, '0, '0);
    vecs[12] = mk(OP_RD,   10'd1000, 10'h000, '0, de, '0);
    vecs[13] = mk(OP_WR,   10'd7,    10'h000, df, '0, '0);
    vecs[14] = mk(OP_RD,   10'd7,    10'h000, '0, '0, INIT2);
    vecs[15] = mk(OP_RD,   10'd2,    10'h000, '0, dd, dd);
    vecs[16] = mk(OP_RD,   10'd0,    10'h000, '0, '0, INIT2);
    vecs[17] = mk(OP_RD,   10'd511,  10'h000, '0, '0, INIT2);
    vecs[18] = mk(OP_RD,   10'd1023, 10'h000, '0, '0, '0);
    vecs[19] = mk(OP_RD,   10'd9,    10'h000, '0, '0, INIT2);

    rst = 1'b1;
    init_req = 1'b0;
    drive(OP_IDLE, '0, '0, '0);
    #3;
    chk("rst_ready_u1", 320'(if1.RW0_ready), 320'(0));
    chk("rst_ready_u2", 320'(if2.RW0_ready), 320'(0));
    chk("rst_rvalid_u1", 320'(if1.RW0_rvalid), 320'(0));
    chk("rst_rvalid_u2", 320'(if2.RW0_rvalid), 320'(0));
    chk("rst_rdata_u1", if1.RW0_rdata, '0);
    chk("rst_rdata_u2", if2.RW0_rdata, '0);

    // Reset lands while the init counter sits at 300.
    @(negedge RW0_clk) rst = 1'b0;
    repeat (300) @(negedge RW0_clk);
    #2 rst = 1'b1;
    #1;
    chk("midinit_ready_u1", 320'(if1.RW0_ready), 320'(0));
    chk("midinit_ready_u2", 320'(if2.RW0_ready), 320'(0));
    chk("midinit_rvalid_u2", 320'(if2.RW0_rvalid), 320'(0));
    @(negedge RW0_clk) rst = 1'b0;
    wait_ready(1024, 1000, 1'b1);

    hold1 = '0;
    hold2 = '0;
    for (int i = 0; i <= NV + 1; i++) begin
      @(negedge RW0_clk);
      if (i >= 1 && i - 1 < NV) begin
        if (vecs[i-1].op == OP_RD) hold1 = vecs[i-1].exp1;
        chk($sformatf("vec%0d_rvalid_u1", i - 1), 320'(if1.RW0_rvalid), 320'(vecs[i-1].op == OP_RD));
        chk($sformatf("vec%0d_rdata_u1", i - 1), if1.RW0_rdata, hold1);
      end
      if (i >= 2) begin
        if (vecs[i-2].op == OP_RD) hold2 = vecs[i-2].exp2;
        chk($sformatf("vec%0d_rvalid_u2", i - 2), 320'(if2.RW0_rvalid), 320'(vecs[i-2].op == OP_RD));
        chk($sformatf("vec%0d_rdata_u2", i - 2), if2.RW0_rdata, hold2);
      end
      if (i < NV) drive(vecs[i].op, vecs[i].addr, vecs[i].wmask, vecs[i].wdata);
      else        drive(OP_IDLE, '0, '0, '0);
    end

    // init_req one edge after a read: the latency-2 read is still in flight and must vanish.
    @(negedge RW0_clk) drive(OP_RD, 10'd2, '0, '0);
    @(negedge RW0_clk);
    chk("inflt_rvalid_u1", 320'(if1.RW0_rvalid), 320'(1));
    chk("inflt_rdata_u1", if1.RW0_rdata, dd);
    chk("inflt_rvalid_u2_a", 320'(if2.RW0_rvalid), 320'(0));
    drive(OP_RD, 10'd3, '0, '0);
    init_req = 1'b1;
    @(negedge RW0_clk);
    chk("reinit_rvalid_u1", 320'(if1.RW0_rvalid), 320'(0));
    chk("reinit_rdata_u1", if1.RW0_rdata, dd);
    chk("reinit_rvalid_u2", 320'(if2.RW0_rvalid), 320'(0));
    chk("reinit_rdata_u2", if2.RW0_rdata, INIT2);
    chk("reinit_ready_u1", 320'(if1.RW0_ready), 320'(0));
    chk("reinit_ready_u2", 320'(if2.RW0_ready), 320'(0));
    drive(OP_IDLE, '0, '0, '0);
    init_req = 1'b0;
    wait_ready(1024, 1000, 1'b0);

    drive(OP_RD, 10'd2, '0, '0);
    @(negedge RW0_clk);
    chk("post_rvalid_u1", 320'(if1.RW0_rvalid), 320'(1));
    chk("post_rdata_u1", if1.RW0_rdata, '0);
    chk("post_rvalid_u2_early", 320'(if2.RW0_rvalid), 320'(0));
    drive(OP_IDLE, '0, '0, '0);
    @(negedge RW0_clk);
    chk("post_rvalid_u1_off", 320'(if1.RW0_rvalid), 320'(0));
    chk("post_rvalid_u2", 320'(if2.RW0_rvalid), 320'(1));
    chk("post_rdata_u2", if2.RW0_rdata, INIT2);

    // Asynchronous reset while u2 is presenting read data.
    #2 rst = 1'b1;
    #1;
    chk("arst_rvalid_u2", 320'(if2.RW0_rvalid), 320'(0));
    chk("arst_rdata_u2", if2.RW0_rdata, '0);
    chk("arst_ready_u1", 320'(if1.RW0_ready), 320'(0));
    chk("arst_ready_u2", 320'(if2.RW0_ready), 320'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sram_sp_init_ext.md
# sram_sp_init_ext

Parametrised single-port masked-write SRAM model with a built-in hardware initialisation engine, selectable read latency (1 or 2 cycles), a read-valid strobe and held read data. It replaces fixed-geometry single-port array models in cache data/tag arrays, where the arrays must reach a known state after reset or on a software-triggered reinit, without a preload pass from the surrounding logic.

## Interface
- DATA_WIDTH, 320: word width in bits; must be a multiple of MASK_GRAN.
- DEPTH, 1024: number of words; need not be a power of two.
- ADDR_WIDTH, 10: address width; must satisfy 2^ADDR_WIDTH >= DEPTH.
- MASK_GRAN, 32: bits per write-mask lane; MASK_WIDTH = DATA_WIDTH/MASK_GRAN.
- RD_LATENCY, 1: 1 or 2; any other value is an elaboration error.
- INIT_VALUE, 0: DATA_WIDTH-wide value written to every word during init.

- RW0_clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-high.
- RW0_addr  input  ADDR_WIDTH  word address.
- RW0_en  input  1  request valid.
- RW0_wmode  input  1  1 = write, 0 = read.
- RW0_wmask  input  MASK_WIDTH  per-lane write enable.
- RW0_wdata  input  DATA_WIDTH  write data.
- init_req  input  1  restart init (level-sampled).
- RW0_ready  output  1  array initialised; requests accepted.
- RW0_rvalid  output  1  one-cycle pulse; RW0_rdata holds new read data.
- RW0_rdata  output  DATA_WIDTH  read data.

## Operation
- FSM states: INIT, READY. Reset (async) forces INIT, init counter = 0, RW0_ready = 0, RW0_rvalid = 0, RW0_rdata = 0, pipeline valids cleared.
- INIT: every cycle writes INIT_VALUE (all lanes) to ram[counter], counter++; on the write to DEPTH-1 → READY. Counter width ADDR_WIDTH+1; no wrap inside INIT.
- READY: RW0_ready = 1. init_req = 1 at an edge → INIT, counter = 0, in-flight read discarded (its rvalid suppressed). init_req is ignored in INIT.
- Requests are accepted only when RW0_ready = 1 at the sampling edge; requests in INIT are dropped silently (no write, no rvalid).
- Write: en && wmode → for each lane i with wmask[i] = 1, ram[addr][i*MASK_GRAN +: MASK_GRAN] <= wdata lane; other lanes are unchanged. wmask = 0 is a legal no-op.
- Read: en && !wmode → data register <= ram[addr] at the sampling edge (RD_LATENCY = 1); with RD_LATENCY = 2, a second register stage captures it one edge later.
- Held data: RW0_rdata changes only when rvalid is asserted; later writes, including ones to the read address, do not alter it.
- Out-of-range (addr >= DEPTH): write dropped; read returns all-zero, rvalid still pulses.
- Same-address write then read on consecutive cycles: the read returns the newly written lanes.
- Same-edge init_req and request in READY: init wins; request dropped.

## Timing
- Read sampled at edge k: RD_LATENCY = 1 → RW0_rdata/RW0_rvalid valid after edge k, rvalid low after edge k+1 unless another read was sampled at k+1. RD_LATENCY = 2 → valid after edge k+1.
- Back-to-back reads: one per cycle, rvalid stays high, data in request order.
- Init duration: DEPTH cycles; RW0_ready rises after the edge that writes word DEPTH-1 and is low for exactly DEPTH cycles after reset release or accepted init_req.
- Write takes effect at the sampling edge; no output activity.
- Reset mid-init or mid-read: immediate return to the reset values; init restarts from 0 on release.

## Configuration
- SRAM_GARBAGE_RDATA_EN defined: on every cycle with RW0_rvalid = 0, RW0_rdata is driven with a fresh $random-derived pattern, regenerated each edge, to expose consumers that sample without rvalid. Simulation only.
- Not defined: RW0_rdata holds the last read value (0 after reset) whenever rvalid = 0.

## Test plan
- Reset release with DEPTH = 1024, INIT_VALUE = 0 → RW0_ready low for 1024 cycles, then high; reads of addresses 0, 511 and 1023 return 0.
- Write addr 5, wdata lanes = lane index, wmask = 10'b0000000101; read addr 5 → lanes 0 and 2 = 0 and 2, others = INIT_VALUE; rvalid is high for one cycle at the configured latency (1 and 2).
- Reads of 1, 2, 3 sampled on consecutive edges → three consecutive rvalid cycles with data in order; then write addr 2 → RW0_rdata unchanged (macro undefined).
- Assert init_req while a read is in flight → no rvalid for that read; ready low for DEPTH cycles; previously written word reads back INIT_VALUE.
- Request issued with RW0_ready = 0, and a read of addr DEPTH with DEPTH = 1000 → no write, no rvalid for the first; rvalid with zero data for the second.
- Assert reset mid-init at counter = 300 → outputs at reset values immediately; after release, full DEPTH-cycle init from 0.
